uart_tx_buffer: RTL and testbench

//   Transmit-side byte FIFO that feeds the uart_ip transmitter. It sits directly upstream of uart_ip.
//   It accepts bytes from a producer (CPU, loopback, test logic) at any rate and stores up to 2**AddrWidth of them.
//   It drains them one at a time into uart_ip's din_i/start_tx_i and waits for tx_done_tick_o before sending the next.

---
 rtl/uart_tx_buffer.sv | 71 +++++++
 tb/tb_uart_tx_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO that paces queued bytes into the uart_ip transmitter one frame at a time
// Ports: clk_i/rst_ni clock and async active-low reset; wr_i/wdata_i producer write strobe and byte;
//   full_o/empty_o/count_o registered occupancy; overflow_o 1-cycle pulse on a dropped write;
//   busy_o frame in flight; tx_din_o/tx_start_o to uart_ip din_i/start_tx_i; tx_done_tick_i from uart_ip.
module uart_tx_buffer #(
  parameter int WordLength = 8,
  parameter int AddrWidth  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_i,
  input  logic [WordLength-1:0] wdata_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [AddrWidth:0]    count_o,
  output logic                  overflow_o,
  output logic                  busy_o,
  output logic [WordLength-1:0] tx_din_o,
  output logic                  tx_start_o,
  input  logic                  tx_done_tick_i
);
  localparam int Depth = 2 ** AddrWidth;
  localparam logic [AddrWidth:0] FullCount = (AddrWidth + 1)'(Depth);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_e;
  state_e                state_q, state_d;
  logic [WordLength-1:0] mem_q [Depth];
  logic [AddrWidth-1:0]  wptr_q, rptr_q;
  logic [AddrWidth:0]    count_q, count_d;
  logic [WordLength-1:0] din_q, din_d;
  logic                  ovf_q, full, empty, pop, push;
  assign full  = count_q == FullCount;
  assign empty = count_q == '0;
  // Popping frees a slot this same edge, so a write to a full FIFO is still taken then.
  assign pop   = (state_q == IDLE) && !empty;
  assign push  = wr_i && (!full || pop);
  always_comb begin
    state_d = state_q == IDLE   ? (empty ? IDLE : LAUNCH) :
              state_q == LAUNCH ? WAIT :
              (tx_done_tick_i ? IDLE : WAIT);
    count_d = count_q + (AddrWidth + 1)'(push) - (AddrWidth + 1)'(pop);
    din_d   = pop ? mem_q[rptr_q] : din_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      din_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_q + AddrWidth'(push);
      rptr_q  <= rptr_q + AddrWidth'(pop);
      count_q <= count_d;
      din_q   <= din_d;
      ovf_q   <= wr_i && full && !pop;
    end
  end
  // Storage needs no reset: the cleared count makes stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign busy_o     = state_q != IDLE;
  assign tx_start_o = state_q == LAUNCH;
  assign tx_din_o   = din_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: self-checking bench for uart_tx_buffer against a queue-based behavioural model
module tb_uart_tx_buffer;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       wr_i = 1'b0;
  logic [7:0] wdata_i = 8'h00;
  logic       tx_done_tick_i = 1'b0;
  logic       full_o, empty_o, overflow_o, busy_o, tx_start_o;
  logic [4:0] count_o;
  logic [7:0] tx_din_o;

  uart_tx_buffer #(.WordLength(8), .AddrWidth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_i(wr_i), .wdata_i(wdata_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .overflow_o(overflow_o),
    .busy_o(busy_o), .tx_din_o(tx_din_o), .tx_start_o(tx_start_o),
    .tx_done_tick_i(tx_done_tick_i)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] q[$];
  logic [7:0] got[$];
  logic [7:0] exp_seq[$];
  bit         m_busy, m_start, m_ovf, chk;
  logic [7:0] m_din;
  int         cmp_n, fail_n, mark, mark2;

  task automatic check(input string name, input int act, input int exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_busy = 0;
    m_start = 0;
    m_ovf = 0;
    m_din = 8'h00;
  endfunction

  // Observable behaviour per edge: a frame goes out whenever nothing is in flight and data waits.
  function automatic void model_step();
    bit can_send, is_full;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    is_full  = q.size() == 16;
    can_send = !m_busy && q.size() > 0;
    m_ovf = wr_i && is_full && !can_send;
    if (can_send) m_din = q.pop_front();
    if (wr_i && (!is_full || can_send)) q.push_back(wdata_i);
    if (can_send) begin
      m_busy = 1;
      m_start = 1;
    end else if (m_start) m_start = 0;
    else if (m_busy && tx_done_tick_i) m_busy = 0;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic write(input logic [7:0] b);
    wr_i = 1'b1;
    wdata_i = b;
    tick();
    wr_i = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      while (!tx_start_o && k < 10) begin
        tick();
        k++;
      end
      check("launch_seen", tx_start_o, 1);
      tick();
      tick();
      tx_done_tick_i = 1'b1;
      tick();
      tx_done_tick_i = 1'b0;
    end
  endtask

  task automatic check_seq(input string name, input int from);
    check({name, "_len"}, got.size() - from, exp_seq.size());
    for (int i = 0; i < exp_seq.size() && from + i < got.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[from+i], exp_seq[i]);
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (chk) begin
        check("count", count_o, q.size());
        check("empty", empty_o, q.size() == 0);
        check("full", full_o, q.size() == 16);
        check("overflow", overflow_o, m_ovf);
        check("busy", busy_o, m_busy);
        check("tx_start", tx_start_o, m_start);
        check("tx_din", tx_din_o, m_din);
        if (tx_start_o) got.push_back(tx_din_o);
      end
    end
  end

  initial begin
    #2 rst_ni = 1'b0;
    model_reset();
    chk = 1;
    for (int i = 0; i < 4; i++) begin
      wr_i = ~wr_i;
      wdata_i = 8'(i * 37 + 5);
      tick();
    end
    wr_i = 1'b0;
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_start", tx_start_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ovf", overflow_o, 0);
    rst_ni = 1'b1;
    tick();
    tick();

    mark = got.size();
    write(8'hA5);
    check("single_count", count_o, 1);
    check("single_empty", empty_o, 0);
    check("single_nostart", tx_start_o, 0);
    tick();
    check("single_start", tx_start_o, 1);
    check("single_din", tx_din_o, 8'hA5);
    check("single_busy", busy_o, 1);
    tick();
    check("single_start_end", tx_start_o, 0);
    repeat (3) tick();
    check("single_wait_busy", busy_o, 1);
    tx_done_tick_i = 1'b1;
    tick();
    tx_done_tick_i = 1'b0;
    check("single_idle", busy_o, 0);
    check("single_drained", empty_o, 1);
    tick();
    exp_seq = '{8'hA5};
    check_seq("single_seq", mark);

    mark = got.size();
    for (int i = 0; i < 16; i++) write(8'(i));
    check("burst_count15", count_o, 15);
    check("burst_notfull", full_o, 0);
    write(8'h10);
    check("burst_full", full_o, 1);
    check("burst_count16", count_o, 16);
    write(8'hFF);
    check("burst_ovf", overflow_o, 1);
    check("burst_ovf_count", count_o, 16);
    tick();
    check("burst_ovf_end", overflow_o, 0);

    tx_done_tick_i = 1'b1;
    tick();
    tx_done_tick_i = 1'b0;
    wr_i = 1'b1;
    wdata_i = 8'h3C;
    tick();
    wr_i = 1'b0;
    check("fullpop_ovf", overflow_o, 0);
    check("fullpop_count", count_o, 16);
    check("fullpop_full", full_o, 1);
    drain(17);
    repeat (3) tick();
    check("burst_empty", empty_o, 1);
    check("burst_idle", busy_o, 0);
    exp_seq.delete();
    for (int i = 0; i <= 16; i++) exp_seq.push_back(8'(i));
    exp_seq.push_back(8'h3C);
    check_seq("burst_seq", mark);

    mark = got.size();
    tx_done_tick_i = 1'b1;
    tick();
    tx_done_tick_i = 1'b0;
    tick();
    check("stray_start", tx_start_o, 0);
    check("stray_busy", busy_o, 0);
    check("stray_empty", empty_o, 1);
    check("stray_nolaunch", got.size(), mark);

    mark = got.size();
    write(8'h11);
    write(8'h22);
    write(8'h33);
    write(8'h44);
    tick();
    check("mid_busy", busy_o, 1);
    check("mid_count", count_o, 3);
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("midrst_count", count_o, 0);
    check("midrst_empty", empty_o, 1);
    check("midrst_busy", busy_o, 0);
    check("midrst_start", tx_start_o, 0);
    check("midrst_din", tx_din_o, 0);
    check("midrst_full", full_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    mark2 = got.size();
    repeat (6) tick();
    check("postrst_nolaunch", got.size(), mark2);
    check("postrst_empty", empty_o, 1);
    exp_seq = '{8'h11};
    check_seq("mid_seq", mark);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
